// File: rtl/lfsr_gen.sv
// Fibonacci LFSR pattern generator with a free-running prescaler, runtime hold/run/step/load
// modes, all-zero lock-up recovery and a period-wrap flag.
module lfsr_gen #(
  parameter int unsigned       WIDTH          = 8,
  parameter logic [WIDTH-1:0]  TAPS           = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED           = WIDTH'(1),
  parameter int unsigned       PRESCALE_WIDTH = 22
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       MODE,
  input  logic             STEP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             BIT,
  output logic             TICK,
  output logic             WRAP,
  output logic             LOCKUP
);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeRun  = 2'b01,
    ModeStep = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(MODE);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]          o_q, o_d;
  logic                      tick_q, tick_d;
  logic                      wrap_q, wrap_d;
  logic                      lockup_q, lockup_d;

  logic             tick_c;
  logic             fb;
  logic             adv;
  logic [WIDTH-1:0] shifted;

  // The counter is all-ones exactly when its increment carries out.
  assign tick_c  = &cnt_q;
  assign fb      = ^(o_q & TAPS);
  assign shifted = {o_q[WIDTH-2:0], fb};

  always_comb begin
    adv = 1'b0;
    unique case (mode)
      ModeHold: adv = 1'b0;
      ModeRun:  adv = tick_c;
      ModeStep: adv = STEP;
      ModeLoad: adv = 1'b0;
      default:  adv = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q + PRESCALE_WIDTH'(1);
    tick_d   = tick_c;
    o_d      = o_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (mode == ModeLoad) begin
      o_d = D;
    end else if (adv) begin
      // All-zero is a fixed point of the shift, so restart from the seed instead.
      if (o_q == '0) begin
        o_d      = SEED;
        lockup_d = 1'b1;
      end else begin
        o_d = shifted;
      end
      wrap_d = (o_d == SEED);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q    <= '0;
      o_q      <= SEED;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign O      = o_q;
  assign BIT    = o_q[WIDTH-1];
  assign TICK   = tick_q;
  assign WRAP   = wrap_q;
  assign LOCKUP = lockup_q;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised Fibonacci LFSR pattern generator with a built-in prescaler, for driving LEDs and headers on icestick-class boards.
- Successor to the fixed 8-bit, free-running LFSR. Adds parametrised width, tap mask, seed and prescale.
- Adds runtime modes: hold, free-run, single-step and parallel load.
- Adds all-zero lock-up recovery and a period-wrap flag.
- Sits between the board clock and GPIO, or feeds downstream test logic.

Parameters:
- WIDTH, 8: LFSR register width, 2..32.
- TAPS, 8'hB8: feedback tap mask, WIDTH bits; bit i=1 puts O[i] in the XOR. The default gives polynomial x^8+x^6+x^5+x^4+1, period 255.
- SEED, 1: reset and recovery state, WIDTH bits, must be nonzero.
- PRESCALE_WIDTH, 22: prescaler counter width; one free-run advance per 2^PRESCALE_WIDTH cycles.

Ports:
- CLK, input, 1: single clock; all state on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- MODE, input, 2: 00 hold, 01 free-run, 10 step, 11 load.
- STEP, input, 1: advance request, used in step mode only.
- D, input, WIDTH: parallel load value.
- O, output, WIDTH: current LFSR state, registered.
- BIT, output, 1: equals O[WIDTH-1], the serial output.
- TICK, output, 1: one-cycle pulse on prescaler wrap, registered.
- WRAP, output, 1: one-cycle pulse when an advance lands on SEED.
- LOCKUP, output, 1: one-cycle pulse when the all-zero state is recovered.

Behaviour:
- Reset, when RESET=1 at a clock edge:
  - O=SEED; prescaler counter=0.
  - TICK, WRAP and LOCKUP = 0.
  - Reset overrides every other input, including mid-load and mid-step.
- Prescaler:
  - Counter increments by 1 every cycle in every mode and wraps modulo 2^PRESCALE_WIDTH.
  - tick_c is true in the cycle where the counter is all-ones, i.e. the carry-out of the increment.
  - TICK register = tick_c, so TICK goes high on the edge where the counter wraps to 0.
- Feedback and advance:
  - fb = XOR-reduce(O AND TAPS).
  - Advance: O_next = {O[WIDTH-2:0], fb}. Bit 0 takes fb; bit k takes bit k-1.
- Advance condition, sampled per edge (adv):
  - MODE=01: adv = tick_c.
  - MODE=10: adv = STEP, one advance per cycle STEP is high. The bench gives single-cycle pulses; a held STEP advances every cycle.
  - MODE=00: adv = 0; O holds. The prescaler keeps running.
  - MODE=11: O = D on every edge. No advance; WRAP=0.
- Lock-up recovery:
  - If O==0 when adv is true, O_next = SEED instead of the shift, and LOCKUP pulses for one cycle.
  - A load of 0 is accepted. O stays 0 while in load or hold; recovery happens on the first advance.
- WRAP:
  - Pulses for one cycle, registered with O, when adv is true and the resulting O_next == SEED, including after a recovery.
  - With the default polynomial, WRAP fires once every 255 advances from the seed.
- Output latency:
  - O, TICK, WRAP and LOCKUP all update on the same edge; there is no extra pipeline stage.
  - BIT is combinational from O[WIDTH-1].
- MODE changes take effect on the next edge. The prescaler phase is never reset except by RESET.
- Simultaneous events:
  - RESET beats load, and load beats advance.
  - In step mode tick_c is ignored for advancing, but TICK still pulses.

Test Plan:
1. Defaults with PRESCALE_WIDTH=2, MODE=01, after RESET:
   - O=01, then on each TICK: 02, 04, 08, 11, 23, 47, 8E, ...
   - TICK pulses every 4 cycles; the first advance is 4 cycles after reset release.
   - After 255 advances O=01 and WRAP=1 for exactly one cycle.
2. MODE=10 with STEP pulses spaced irregularly: O advances exactly once per pulse, independent of TICK. MODE=00 then holds O through 10 TICKs.
3. MODE=11 with D=8'h80 for one cycle, then MODE=01: O=80, then next advance gives fb=1 (bit 7) and O=01 with WRAP=1.
4. Lock-up:
   - MODE=11 with D=0, then MODE=10 and STEP: O=0 until the step, then O=SEED=01 with LOCKUP=1 and WRAP=1 in the same cycle.
   - No LOCKUP pulse occurs on normal steps.
5. RESET asserted mid free-run, coincident with TICK and with MODE=11: on the next edge O=SEED, counter=0 and all pulses are 0. The counter restarts from 0.
6. WIDTH=4, TAPS=4'hC, SEED=4'h1: full-period sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1. WRAP asserts only on the return to 1.
